// File: rtl/processor_data_memory.sv
// Stage-2 data-memory responder: word-addressed block RAM plus a 4-register I/O window
// (OUT port, input FIFO, status, cycle counter). Read data is registered, 1-cycle latency.
module processor_data_memory #(
  parameter int                    ADDR_SIZE     = 18,
  parameter int                    WORD_SIZE     = 18,
  parameter int                    RAM_ADDR_BITS = 10,
  parameter logic [ADDR_SIZE-1:0]  IO_BASE       = 18'h3FF00,
  parameter int                    FIFO_DEPTH    = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [ADDR_SIZE-1:0] memory_addr,
  input  logic                 memory_write_enable,
  input  logic [WORD_SIZE-1:0] memory_in,
  output logic [WORD_SIZE-1:0] memory_out,
  output logic [WORD_SIZE-1:0] io_out_data,
  output logic                 io_out_strobe,
  input  logic [WORD_SIZE-1:0] io_in_data,
  input  logic                 io_in_valid,
  output logic                 io_in_full
);

  localparam int IDX_W = $clog2(FIFO_DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam int RAM_DEPTH = 2 ** RAM_ADDR_BITS;
  localparam logic [ADDR_SIZE-1:0] RAM_LIMIT = ADDR_SIZE'(RAM_DEPTH);
  localparam logic [ADDR_SIZE-1:0] ADDR_OUT  = IO_BASE;
  localparam logic [ADDR_SIZE-1:0] ADDR_FIFO = IO_BASE + ADDR_SIZE'(1);
  localparam logic [ADDR_SIZE-1:0] ADDR_STAT = IO_BASE + ADDR_SIZE'(2);
  localparam logic [ADDR_SIZE-1:0] ADDR_CNT  = IO_BASE + ADDR_SIZE'(3);

  logic [WORD_SIZE-1:0] ram_q [RAM_DEPTH];
  logic [WORD_SIZE-1:0] fifo_mem_q [FIFO_DEPTH];

  logic [WORD_SIZE-1:0] memory_out_q, memory_out_d;
  logic [WORD_SIZE-1:0] io_out_data_q, io_out_data_d;
  logic                 io_out_strobe_q, io_out_strobe_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic                 overflow_q, overflow_d;
  logic [WORD_SIZE-1:0] counter_q, counter_d;

  logic                 is_ram, sel_out, sel_fifo, sel_stat, sel_cnt;
  logic [PTR_W-1:0]     fifo_count;
  logic                 fifo_full, fifo_empty;
  logic                 pop, push_ok, ovf_evt, ovf_clr;
  logic                 ram_we;
  logic [WORD_SIZE-1:0] fifo_head;

  assign is_ram   = memory_addr < RAM_LIMIT;
  assign sel_out  = memory_addr == ADDR_OUT;
  assign sel_fifo = memory_addr == ADDR_FIFO;
  assign sel_stat = memory_addr == ADDR_STAT;
  assign sel_cnt  = memory_addr == ADDR_CNT;

  assign fifo_count = wr_ptr_q - rd_ptr_q;
  assign fifo_full  = fifo_count == PTR_W'(FIFO_DEPTH);
  assign fifo_empty = fifo_count == '0;
  assign fifo_head  = fifo_mem_q[rd_ptr_q[IDX_W-1:0]];

  // A pop frees a slot in the same cycle, so push+pop while full is accepted.
  assign pop     = memory_write_enable & sel_fifo & ~fifo_empty;
  assign push_ok = io_in_valid & (~fifo_full | pop);
  assign ovf_evt = io_in_valid & fifo_full & ~pop;
  assign ovf_clr = memory_write_enable & sel_stat & memory_in[2];
  assign ram_we  = memory_write_enable & is_ram & ~reset;

  always_comb begin
    memory_out_d    = '0;
    io_out_data_d   = io_out_data_q;
    io_out_strobe_d = 1'b0;
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    overflow_d      = overflow_q;
    counter_d       = counter_q + WORD_SIZE'(1);

    if (is_ram)        memory_out_d = ram_q[memory_addr[RAM_ADDR_BITS-1:0]];
    else if (sel_out)  memory_out_d = io_out_data_q;
    else if (sel_fifo) memory_out_d = fifo_empty ? '0 : fifo_head;
    else if (sel_stat) memory_out_d = WORD_SIZE'({overflow_q, fifo_full, ~fifo_empty});
    else if (sel_cnt)  memory_out_d = counter_q;

    if (memory_write_enable && sel_out) begin
      io_out_data_d   = memory_in;
      io_out_strobe_d = 1'b1;
    end

    if (pop)     rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);

    // A new overflow wins over a simultaneous clear.
    if (ovf_clr) overflow_d = 1'b0;
    if (ovf_evt) overflow_d = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      memory_out_q    <= '0;
      io_out_data_q   <= '0;
      io_out_strobe_q <= 1'b0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      overflow_q      <= 1'b0;
      counter_q       <= '0;
    end else begin
      memory_out_q    <= memory_out_d;
      io_out_data_q   <= io_out_data_d;
      io_out_strobe_q <= io_out_strobe_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      overflow_q      <= overflow_d;
      counter_q       <= counter_d;
    end
  end

  always_ff @(posedge clock) begin
    if (ram_we) ram_q[memory_addr[RAM_ADDR_BITS-1:0]] <= memory_in;
  end

  always_ff @(posedge clock) begin
    if (push_ok && !reset) fifo_mem_q[wr_ptr_q[IDX_W-1:0]] <= io_in_data;
  end

  assign memory_out    = memory_out_q;
  assign io_out_data   = io_out_data_q;
  assign io_out_strobe = io_out_strobe_q;
  assign io_in_full    = fifo_full;

endmodule

// File: tb/tb_processor_data_memory.sv
// Directed bench for processor_data_memory: a queue/array model checked every cycle,
// plus literal expectations for the hand-worked scenarios.
module tb_processor_data_memory;

  localparam logic [17:0] IO0 = 18'h3FF00;
  localparam logic [17:0] IO1 = 18'h3FF01;
  localparam logic [17:0] IO2 = 18'h3FF02;
  localparam logic [17:0] IO3 = 18'h3FF03;
  localparam logic [17:0] UNM = 18'h20000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [17:0] memory_addr = UNM;
  logic        memory_write_enable = 1'b0;
  logic [17:0] memory_in = '0;
  logic [17:0] memory_out;
  logic [17:0] io_out_data;
  logic        io_out_strobe;
  logic [17:0] io_in_data = '0;
  logic        io_in_valid = 1'b0;
  logic        io_in_full;

  int vectors = 0;
  int miscompares = 0;
  bit checking = 0;

  processor_data_memory dut (
    .clock(clock), .reset(reset),
    .memory_addr(memory_addr), .memory_write_enable(memory_write_enable),
    .memory_in(memory_in), .memory_out(memory_out),
    .io_out_data(io_out_data), .io_out_strobe(io_out_strobe),
    .io_in_data(io_in_data), .io_in_valid(io_in_valid), .io_in_full(io_in_full)
  );

  always #5 clock = ~clock;

  // Behavioural model
  logic [17:0] m_ram [1024];
  logic [17:0] m_fifo [$];
  logic [17:0] m_out_data = '0;
  logic [17:0] m_cnt = '0;
  logic [17:0] e_mem_out = '0;
  logic        e_strobe = 1'b0;
  bit          m_ovf = 0;

  always @(posedge clock) begin
    if (reset) begin
      e_mem_out = '0; m_out_data = '0; e_strobe = 1'b0;
      m_fifo.delete(); m_ovf = 0; m_cnt = '0;
    end else begin
      bit pop, was_full, clr;
      if (memory_addr < 18'd1024)  e_mem_out = m_ram[memory_addr[9:0]];
      else if (memory_addr == IO0) e_mem_out = m_out_data;
      else if (memory_addr == IO1) e_mem_out = (m_fifo.size() > 0) ? m_fifo[0] : 18'd0;
      else if (memory_addr == IO2) e_mem_out = {15'd0, m_ovf, m_fifo.size() == 4, m_fifo.size() != 0};
      else if (memory_addr == IO3) e_mem_out = m_cnt;
      else                         e_mem_out = '0;
      e_strobe = memory_write_enable && memory_addr == IO0;
      if (e_strobe) m_out_data = memory_in;
      if (memory_write_enable && memory_addr < 18'd1024) m_ram[memory_addr[9:0]] = memory_in;
      was_full = m_fifo.size() == 4;
      pop = memory_write_enable && memory_addr == IO1 && m_fifo.size() > 0;
      clr = memory_write_enable && memory_addr == IO2 && memory_in[2];
      if (pop) void'(m_fifo.pop_front());
      if (clr) m_ovf = 0;
      if (io_in_valid) begin
        if (!was_full || pop) m_fifo.push_back(io_in_data);
        else m_ovf = 1;
      end
      m_cnt = m_cnt + 18'd1;
    end
  end

  task automatic chk(string name, logic [17:0] act, logic [17:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (checking) begin
      chk("memory_out", memory_out, e_mem_out);
      chk("io_out_data", io_out_data, m_out_data);
      chk("io_out_strobe", {17'd0, io_out_strobe}, {17'd0, e_strobe});
      chk("io_in_full", {17'd0, io_in_full}, {17'd0, m_fifo.size() == 4});
    end
  end

  // Drive one cycle; returns just after the capturing edge.
  task automatic step(input logic [17:0] a, input logic we = 0, input logic [17:0] d = 0,
                      input logic v = 0, input logic [17:0] vd = 0, input logic rst = 0);
    @(negedge clock); #1;
    reset = rst; memory_addr = a; memory_write_enable = we; memory_in = d;
    io_in_valid = v; io_in_data = vd;
    @(posedge clock); #1;
  endtask

  task automatic push(input logic [17:0] v);
    step(UNM, 0, 0, 1, v);
  endtask

  initial begin
    @(posedge clock); #1;
    checking = 1;
    step(UNM, 0, 0, 0, 0, 1);
    // 1: status and counter
    step(IO2);            chk("t1 status", memory_out, 18'd0);
    step(IO3);            chk("t1 cnt a", memory_out, 18'd1);
    step(IO3);            chk("t1 cnt b", memory_out, 18'd2);
    // 2: RAM, read-first
    step(18'd5, 1, 18'h2A5A5);
    step(18'd5);          chk("t2 rd", memory_out, 18'h2A5A5);
    step(18'd5, 1, 18'h1); chk("t2 rdw old", memory_out, 18'h2A5A5);
    step(18'd5);          chk("t2 rdw new", memory_out, 18'h1);
    // 3: OUT port
    step(IO0, 1, 18'h12345);
    chk("t3 data", io_out_data, 18'h12345); chk("t3 strobe", {17'd0, io_out_strobe}, 18'd1);
    step(IO0);            chk("t3 rd", memory_out, 18'h12345);
    chk("t3 strobe off", {17'd0, io_out_strobe}, 18'd0);
    step(IO0, 1, 18'h111); step(IO0, 1, 18'h222);
    chk("t3 b2b strobe", {17'd0, io_out_strobe}, 18'd1);
    // 4: fill, overflow, clear
    push(18'd1); push(18'd2); push(18'd3); push(18'd4);
    step(IO2);            chk("t4 full st", memory_out, 18'b011);
    chk("t4 full pin", {17'd0, io_in_full}, 18'd1);
    push(18'd5);
    step(IO2);            chk("t4 ovf st", memory_out, 18'b111);
    step(IO1);            chk("t4 head", memory_out, 18'd1);
    step(IO2, 1, 18'h4);
    step(IO2);            chk("t4 clr st", memory_out, 18'b011);
    // 5: push+pop while full, drain
    step(IO1, 1, 18'd0, 1, 18'd6);
    step(IO2);            chk("t5 no ovf", memory_out, 18'b011);
    step(IO1, 1);         chk("t5 pop2", memory_out, 18'd2);
    step(IO1, 1);         chk("t5 pop3", memory_out, 18'd3);
    step(IO1, 1);         chk("t5 pop4", memory_out, 18'd4);
    step(IO1, 1);         chk("t5 pop6", memory_out, 18'd6);
    step(IO1);            chk("t5 empty rd", memory_out, 18'd0);
    step(IO2);            chk("t5 empty st", memory_out, 18'd0);
    step(IO1, 1);
    step(IO2);            chk("t5 extra pop", memory_out, 18'd0);
    step(IO1, 1, 18'd0, 1, 18'd7);
    step(IO1);            chk("t5 empty pushpop", memory_out, 18'd7);
    // 6: unmapped, reset mid-operation
    step(UNM);            chk("t6 unm rd", memory_out, 18'd0);
    step(UNM, 1, 18'h3FFFF);
    step(18'd5);          chk("t6 ram kept", memory_out, 18'h1);
    step(IO0);            chk("t6 out kept", memory_out, 18'h222);
    push(18'd8);
    step(18'd5, 1, 18'h777, 1, 18'd9, 1);
    chk("t6 rst mo", memory_out, 18'd0); chk("t6 rst out", io_out_data, 18'd0);
    step(IO2);            chk("t6 rst st", memory_out, 18'd0);
    step(18'd5);          chk("t6 rst ram", memory_out, 18'h1);
    step(UNM);
    checking = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
